// File: rtl/xgmii_pkg.sv
// XGMII symbol constants, framer state encoding and the keep-to-length helper
// shared by the transmit framer.
package xgmii_pkg;

  localparam logic [7:0]  XG_IDLE     = 8'h07;
  localparam logic [7:0]  XG_START    = 8'hFB;
  localparam logic [7:0]  XG_TERM     = 8'hFD;
  localparam logic [7:0]  XG_ERR      = 8'hFE;
  localparam logic [63:0] XG_PREAMBLE = 64'hD5555555555555FB;

  typedef enum logic [2:0] {IDLE, DATA, TERM, DROP, IFG} state_t;

  // Number of valid bytes on an eop beat: contiguous ones from keep[0];
  // an empty run (keep[0]==0, including keep==0) means a full 8-byte beat.
  function automatic logic [3:0] keep2len(input logic [7:0] keep);
    logic [3:0] n;
    logic       run;
    n   = 4'd0;
    run = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (run && keep[i]) n = n + 4'd1;
      else                run = 1'b0;
    end
    return (n == 4'd0) ? 4'd8 : n;
  endfunction

endpackage

// File: rtl/xgmii_tx_framer.sv
// Packet-stream to 64-bit XGMII TX framer: preamble, data lanes, /T/ placement,
// error/abort signalling and deficit-aware inter-frame gap.
module xgmii_tx_framer
  import xgmii_pkg::*;
#(
  parameter int IFG_WORDS = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        s_axis_valid_i,
  input  logic [63:0] s_axis_data_i,
  input  logic [7:0]  s_axis_keep_i,
  input  logic        s_axis_sop_i,
  input  logic        s_axis_eop_i,
  input  logic        s_axis_err_i,
  output logic        s_axis_ready_o,
  output logic [63:0] xgmii_txd_o,
  output logic [7:0]  xgmii_txc_o,
  output logic [31:0] tx_frames_o,
  output logic [31:0] tx_aborts_o
);

  localparam logic [63:0] IDLE_WORD = {8{XG_IDLE}};
  localparam logic [63:0] ERR_WORD  = {8{XG_ERR}};
  localparam logic [63:0] TERM_WORD = {{7{XG_IDLE}}, XG_TERM};

  state_t      r_state;
  logic [63:0] r_txd;
  logic [7:0]  r_txc;
  logic [31:0] r_frames;
  logic [31:0] r_aborts;
  logic [3:0]  r_ifg_cnt;
  logic        r_first;
  logic        r_bad;
  logic        r_drop;

  logic [3:0]  w_len;
  logic [71:0] w_tail;

  // Idle words still owed after the current one (K-1); the extra word tops
  // up the gap when the /T/ word plus the minimum IFG carry fewer than 12 idles.
  function automatic logic [3:0] ifg_reload(input logic [3:0] idle_bytes);
    int total;
    total = int'(idle_bytes) + 8 * IFG_WORDS;
    return (total < 12) ? 4'(IFG_WORDS) : 4'(IFG_WORDS - 1);
  endfunction

  function automatic logic [71:0] tail_word(input logic [63:0] d, input logic [3:0] n);
    logic [63:0] txd;
    logic [7:0]  txc;
    for (int i = 0; i < 8; i++) begin
      if (i < int'(n)) begin
        txd[8*i +: 8] = d[8*i +: 8];
        txc[i]        = 1'b0;
      end else if (i == int'(n)) begin
        txd[8*i +: 8] = XG_TERM;
        txc[i]        = 1'b1;
      end else begin
        txd[8*i +: 8] = XG_IDLE;
        txc[i]        = 1'b1;
      end
    end
    return {txd, txc};
  endfunction

  assign w_len  = keep2len(s_axis_keep_i);
  assign w_tail = tail_word(s_axis_data_i, w_len);

  assign s_axis_ready_o = (r_state == DATA) || (r_state == DROP);
  assign xgmii_txd_o    = r_txd;
  assign xgmii_txc_o    = r_txc;
  assign tx_frames_o    = r_frames;
  assign tx_aborts_o    = r_aborts;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= IDLE;
      r_txd     <= IDLE_WORD;
      r_txc     <= 8'hFF;
      r_frames  <= 32'd0;
      r_aborts  <= 32'd0;
      r_ifg_cnt <= 4'd0;
      r_first   <= 1'b0;
      r_bad     <= 1'b0;
      r_drop    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_txd <= IDLE_WORD;
          r_txc <= 8'hFF;
          // The sop beat stays on the bus and is taken in DATA next cycle.
          if (s_axis_valid_i && s_axis_sop_i) begin
            r_txd   <= XG_PREAMBLE;
            r_txc   <= 8'h01;
            r_first <= 1'b1;
            r_bad   <= 1'b0;
            r_drop  <= 1'b0;
            r_state <= DATA;
          end
        end
        DATA: begin
          if (!s_axis_valid_i) begin
            r_txd    <= ERR_WORD;
            r_txc    <= 8'hFF;
            r_aborts <= r_aborts + 32'd1;
            r_bad    <= 1'b1;
            r_drop   <= 1'b1;
            r_state  <= TERM;
          end else if (s_axis_sop_i && !r_first) begin
            r_txd    <= ERR_WORD;
            r_txc    <= 8'hFF;
            r_aborts <= r_aborts + 32'd1;
            r_bad    <= 1'b1;
            r_drop   <= !s_axis_eop_i;
            r_state  <= TERM;
          end else begin
            r_first <= 1'b0;
            if (s_axis_err_i) begin
              r_txd <= ERR_WORD;
              r_txc <= 8'hFF;
              r_bad <= 1'b1;
              if (s_axis_eop_i) r_state <= TERM;
            end else if (s_axis_eop_i && (w_len != 4'd8)) begin
              {r_txd, r_txc} <= w_tail;
              r_ifg_cnt      <= ifg_reload(4'd7 - w_len);
              if (!r_bad) r_frames <= r_frames + 32'd1;
              r_state        <= IFG;
            end else begin
              r_txd <= s_axis_data_i;
              r_txc <= 8'h00;
              if (s_axis_eop_i) r_state <= TERM;
            end
          end
        end
        TERM: begin
          r_txd     <= TERM_WORD;
          r_txc     <= 8'hFF;
          r_ifg_cnt <= ifg_reload(4'd7);
          if (!r_bad) r_frames <= r_frames + 32'd1;
          r_state   <= r_drop ? DROP : IFG;
        end
        DROP: begin
          r_txd <= IDLE_WORD;
          r_txc <= 8'hFF;
          if (s_axis_valid_i && s_axis_eop_i) r_state <= IFG;
        end
        IFG: begin
          r_txd <= IDLE_WORD;
          r_txc <= 8'hFF;
          if (r_ifg_cnt == 4'd0) r_state   <= IDLE;
          else                   r_ifg_cnt <= r_ifg_cnt - 4'd1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xgmii_tx_framer.sv
// Randomized and directed bench for xgmii_tx_framer: each frame is turned into
// its expected XGMII word sequence and gap, then matched against the captured stream.
module tb_xgmii_tx_framer;

  localparam int IFG_WORDS = 1;
  localparam logic [71:0] IDLE_W = {64'h0707070707070707, 8'hFF};
  localparam logic [71:0] PRE_W  = {64'hD5555555555555FB, 8'h01};
  localparam logic [71:0] TERM_W = {64'h07070707070707FD, 8'hFF};
  localparam logic [71:0] ERR_W  = {64'hFEFEFEFEFEFEFEFE, 8'hFF};
  localparam int K_NORMAL = 0, K_ERR = 1, K_UNDER = 2, K_MISS = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [63:0] data;
  logic [7:0]  keep;
  logic        sop, eop, err;
  logic        ready;
  logic [63:0] txd;
  logic [7:0]  txc;
  logic [31:0] frames, aborts;

  always #5 clk = ~clk;

  xgmii_tx_framer #(.IFG_WORDS(IFG_WORDS)) u_dut (
    .clk_i(clk), .rst_i(rst),
    .s_axis_valid_i(valid), .s_axis_data_i(data), .s_axis_keep_i(keep),
    .s_axis_sop_i(sop), .s_axis_eop_i(eop), .s_axis_err_i(err),
    .s_axis_ready_o(ready),
    .xgmii_txd_o(txd), .xgmii_txc_o(txc),
    .tx_frames_o(frames), .tx_aborts_o(aborts)
  );

  int checks = 0;
  int failures = 0;
  int exp_frames = 0;
  int exp_aborts = 0;
  logic [71:0] obs_q[$];
  logic [71:0] exp_q[$];
  int f_start[$], f_len[$], f_idle[$];
  bit f_exact[$];
  bit mon_en = 1'b0;

  always @(negedge clk) if (mon_en) obs_q.push_back({txd, txc});

  function automatic bit chk(input string tag, input logic [71:0] o, input logic [71:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
    return (o === e);
  endfunction

  // Idle words owed after a /T/ word that itself carries idle_bytes idles.
  function automatic int kwords(input int idle_bytes);
    return IFG_WORDS + (((idle_bytes + 8 * IFG_WORDS) < 12) ? 1 : 0);
  endfunction

  function automatic logic [71:0] tail_exp(input logic [63:0] d, input int n);
    logic [63:0] w;
    logic [7:0]  c;
    w = 64'h0707070707070707;
    for (int i = 0; i < n; i++) w[8*i +: 8] = d[8*i +: 8];
    w[8*n +: 8] = 8'hFD;
    c = 8'hFF << n;
    return {w, c};
  endfunction

  task automatic drive_beat(input logic [63:0] d, input logic [7:0] k,
                            input bit s, input bit e, input bit x);
    int n;
    bit acc;
    valid = 1'b1; data = d; keep = k; sop = s; eop = e; err = x;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = ready;
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    assert (acc) else begin
      failures++;
      $error("FAIL handshake_timeout observed=not_accepted expected=accepted");
    end
  endtask

  task automatic run_frame(input int kind, input int nb, input int n_last,
                           input int err_idx, input int under_u, input int gap);
    logic [63:0] d;
    logic [7:0]  lk, mask, rnd;
    int          start;
    bit          bad;
    bit          last;
    bit          e;
    if (f_len.size() > 0 && gap == 0) f_exact[f_exact.size() - 1] = 1'b1;
    if (gap > 0) begin
      valid = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
    end
    rnd = 8'($urandom);
    if (n_last == 8) lk = $urandom_range(0, 1) ? 8'hFF : 8'h00;
    else begin
      mask = (8'h01 << n_last) - 8'h01;
      lk   = mask | (rnd & (8'hFE << n_last));
    end
    start = exp_q.size();
    exp_q.push_back(PRE_W);
    bad = 1'b0;
    for (int b = 0; b < nb; b++) begin
      if (kind == K_UNDER && b == under_u) begin
        valid = 1'b0;
        @(posedge clk);
        #1;
        for (int rb = b; rb < nb; rb++)
          drive_beat({$urandom, $urandom}, (rb == nb - 1) ? lk : 8'($urandom),
                     1'b0, rb == nb - 1, 1'b0);
        exp_q.push_back(ERR_W);
        exp_q.push_back(TERM_W);
        f_idle.push_back((nb - b) + kwords(7));
        exp_aborts++;
        break;
      end
      last = (b == nb - 1) && (kind != K_MISS);
      e    = (kind == K_ERR) && (b == err_idx);
      d    = {$urandom, $urandom};
      drive_beat(d, last ? lk : 8'($urandom), b == 0, last, e);
      if (e) begin
        exp_q.push_back(ERR_W);
        bad = 1'b1;
        if (last) begin
          exp_q.push_back(TERM_W);
          f_idle.push_back(kwords(7));
        end
      end else if (last) begin
        if (n_last == 8) begin
          exp_q.push_back({d, 8'h00});
          exp_q.push_back(TERM_W);
          f_idle.push_back(kwords(7));
        end else begin
          exp_q.push_back(tail_exp(d, n_last));
          f_idle.push_back(kwords(7 - n_last));
        end
        if (!bad) exp_frames++;
      end else begin
        exp_q.push_back({d, 8'h00});
      end
    end
    if (kind == K_MISS) begin
      drive_beat({$urandom, $urandom}, 8'($urandom), 1'b1, 1'b1, 1'b0);
      exp_q.push_back(ERR_W);
      exp_q.push_back(TERM_W);
      f_idle.push_back(kwords(7));
      exp_aborts++;
    end
    valid = 1'b0; sop = 1'b0; eop = 1'b0; err = 1'b0;
    f_start.push_back(start);
    f_len.push_back(exp_q.size() - start);
    f_exact.push_back(1'b0);
  endtask

  initial begin
    int kind, nb, n_last, err_idx, under_u, gap, p, idl;
    bit ok;
    rst = 1'b1; valid = 1'b0; data = '0; keep = '0; sop = 1'b0; eop = 1'b0; err = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    void'(chk("reset_txd_txc", {txd, txc}, IDLE_W));
    void'(chk("reset_ready", 72'(ready), 72'(0)));
    void'(chk("reset_frames", 72'(frames), 72'(0)));
    void'(chk("reset_aborts", 72'(aborts), 72'(0)));
    @(posedge clk);
    #1;
    rst = 1'b0;
    mon_en = 1'b1;

    // Directed frames: 64B, 61B, 67B followed back-to-back, underrun, err, missing eop.
    run_frame(K_NORMAL, 8, 8, -1, -1, 2);
    run_frame(K_NORMAL, 8, 5, -1, -1, 0);
    run_frame(K_NORMAL, 9, 3, -1, -1, 0);
    run_frame(K_NORMAL, 2, 8, -1, -1, 0);
    run_frame(K_UNDER, 10, 8, -1, 3, 0);
    run_frame(K_ERR, 6, 8, 1, -1, 0);
    run_frame(K_MISS, 3, 8, -1, -1, 0);
    run_frame(K_NORMAL, 1, 4, -1, -1, 0);

    for (int i = 0; i < 40; i++) begin
      kind    = $urandom_range(0, 9);
      kind    = (kind < 6) ? K_NORMAL : (kind < 8) ? K_ERR : (kind == 8) ? K_UNDER : K_MISS;
      nb      = $urandom_range(1, 12);
      if (kind == K_UNDER && nb < 2) nb = 2;
      n_last  = $urandom_range(1, 8);
      err_idx = $urandom_range(0, nb - 1);
      under_u = (nb > 1) ? $urandom_range(1, nb - 1) : 1;
      gap     = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
      run_frame(kind, nb, n_last, err_idx, under_u, gap);
    end

    repeat (30) @(posedge clk);
    #1;
    mon_en = 1'b0;

    p  = 0;
    ok = 1'b1;
    for (int f = 0; f < f_len.size() && ok; f++) begin
      idl = 0;
      while (p < obs_q.size() && obs_q[p] === IDLE_W) begin idl++; p++; end
      if (f > 0) begin
        if (f_exact[f-1]) ok = chk($sformatf("idle_gap_f%0d", f), 72'(idl), 72'(f_idle[f-1]));
        else begin
          checks++;
          assert (idl >= f_idle[f-1]) else begin
            failures++; ok = 1'b0;
            $error("FAIL min_idle_gap_f%0d observed=%0d expected>=%0d", f, idl, f_idle[f-1]);
          end
        end
      end
      for (int w = 0; w < f_len[f] && ok; w++) begin
        if (p >= obs_q.size()) begin
          checks++; failures++; ok = 1'b0;
          $error("FAIL stream_short_f%0d observed=%0d words expected=more", f, obs_q.size());
        end else begin
          ok = chk($sformatf("frame%0d_word%0d", f, w), obs_q[p], exp_q[f_start[f] + w]);
          p++;
        end
      end
    end
    if (ok) begin
      idl = 0;
      while (p < obs_q.size() && obs_q[p] === IDLE_W) begin idl++; p++; end
      checks++;
      assert (idl >= f_idle[f_idle.size() - 1]) else begin
        failures++;
        $error("FAIL trailing_idle observed=%0d expected>=%0d", idl, f_idle[f_idle.size() - 1]);
      end
      void'(chk("trailing_only_idle", 72'(p), 72'(obs_q.size())));
    end

    @(negedge clk);
    void'(chk("tx_frames", 72'(frames), 72'(exp_frames)));
    void'(chk("tx_aborts", 72'(aborts), 72'(exp_aborts)));

    // Reset in the middle of a frame's data phase.
    @(posedge clk);
    #1;
    drive_beat({$urandom, $urandom}, 8'hFF, 1'b1, 1'b0, 1'b0);
    drive_beat({$urandom, $urandom}, 8'hFF, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    valid = 1'b0;
    @(posedge clk);
    #1;
    void'(chk("midreset_txd_txc", {txd, txc}, IDLE_W));
    void'(chk("midreset_ready", 72'(ready), 72'(0)));
    void'(chk("midreset_frames", 72'(frames), 72'(0)));
    void'(chk("midreset_aborts", 72'(aborts), 72'(0)));
    rst = 1'b0;
    @(posedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
